// File: rtl/bram_arbiter.sv
// bram_arbiter: two-requester round-robin arbiter and sequencer for one
// 32-bit BlockRAM tile. It issues at most one read or write per cycle and
// steers each read response back to the requester that asked for it.
// Optional build macro BRAM_ARB_CLEAR_EN: zero-fills the whole RAM after
// reset before any request is accepted.
//
// Handshake: req_valid[i] is held by requester i; req_ready[i] is
// combinational and is high only for the single granted requester while the
// block is running; a request is consumed on the rising edge where
// req_valid[i] && req_ready[i]. Responses (rsp_valid) are one-cycle strobes
// with no back-pressure, returned in issue order.
module bram_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [1:0]              req_we,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [ADDR_WIDTH-1:0]   bram_rd_addr,
   output logic [ADDR_WIDTH-1:0]   bram_wr_addr,
   output logic [DATA_WIDTH-1:0]   bram_wr_data,
   output logic                    bram_we,
   input  logic [DATA_WIDTH-1:0]   bram_rd_data,
   output logic                    init_done
);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                  state;
   logic                    ptr;
   logic                    gnt_idx;
   logic                    accept;
   logic                    rd_issue;
   logic [1:0]              gnt;
   logic                    sel_we;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata;
   // Stage 0 lines up with bram_rd_addr; the last stage lines up with
   // bram_rd_data, RD_LATENCY cycles later.
   logic [RD_LATENCY:0]     pipe_v;
   logic [RD_LATENCY:0]     pipe_tag;
`ifdef BRAM_ARB_CLEAR_EN
   // One extra bit so the "all words written" condition is the MSB.
   logic [ADDR_WIDTH:0]     clr_cnt;
`endif

   // Round-robin grant: pointer wins on contention, otherwise the lone requester.
   always_comb begin
      gnt     = 2'b00;
      gnt_idx = 1'b0;
      if (req_valid == 2'b11) begin
         gnt_idx = ptr;
      end else begin
         gnt_idx = req_valid[1];
      end
      // init_done is registered, so the first cycle after reset never grants.
      accept = rst_n && (state == ST_RUN) && init_done && (req_valid != 2'b00);
      if (accept) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

   assign req_ready = gnt;
   assign sel_we    = gnt_idx ? req_we[1] : req_we[0];
   assign sel_addr  = gnt_idx ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                              : req_addr[0 +: ADDR_WIDTH];
   assign sel_wdata = gnt_idx ? req_wdata[DATA_WIDTH +: DATA_WIDTH]
                              : req_wdata[0 +: DATA_WIDTH];
   assign rd_issue  = accept && !sel_we;

   // Response strobe goes to the tagged requester; silenced while in reset so
   // nothing in flight leaks out during the reset cycle.
   assign rsp_valid = (rst_n && pipe_v[RD_LATENCY])
                      ? (pipe_tag[RD_LATENCY] ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_rdata = bram_rd_data;

   // Control FSM, BRAM port registers, pointer and response tag pipe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
`ifdef BRAM_ARB_CLEAR_EN
         state   <= ST_INIT;
         clr_cnt <= '0;
`else
         state   <= ST_RUN;
`endif
         init_done    <= 1'b0;
         ptr          <= 1'b0;
         bram_we      <= 1'b0;
         bram_rd_addr <= '0;
         bram_wr_addr <= '0;
         bram_wr_data <= '0;
         pipe_v       <= '0;
         pipe_tag     <= '0;
      end else begin
         bram_we <= 1'b0;
         if (RD_LATENCY > 0) begin
            pipe_v   <= {pipe_v[RD_LATENCY-1:0], rd_issue};
            pipe_tag <= {pipe_tag[RD_LATENCY-1:0], gnt_idx};
         end
         case (state)
            ST_INIT: begin
`ifdef BRAM_ARB_CLEAR_EN
               if (clr_cnt[ADDR_WIDTH]) begin
                  // Last zero write already issued last cycle.
                  state     <= ST_RUN;
                  init_done <= 1'b1;
               end else begin
                  bram_we      <= 1'b1;
                  bram_wr_addr <= clr_cnt[ADDR_WIDTH-1:0];
                  bram_wr_data <= '0;
                  clr_cnt      <= clr_cnt + 1'b1;
               end
`else
               state <= ST_RUN;
`endif
            end
            ST_RUN: begin
               init_done <= 1'b1;
               if (accept) begin
                  ptr <= ~gnt_idx;
                  if (sel_we) begin
                     bram_we      <= 1'b1;
                     bram_wr_addr <= sel_addr;
                     bram_wr_data <= sel_wdata;
                  end else begin
                     bram_rd_addr <= sel_addr;
                  end
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: a vector table for the per-cycle
// handshake / response / write-port behaviour, plus hand-written sequences
// for read latency, mid-flight reset and (with BRAM_ARB_CLEAR_EN) the
// post-reset zero fill. A small BRAM model sits on the tile ports.
module tb_bram_arbiter;

   localparam int AW     = 8;
   localparam int DW     = 32;
   localparam int RD_LAT = 1;
`ifdef BRAM_ARB_CLEAR_EN
   localparam int INIT_CYC = 257;
`else
   localparam int INIT_CYC = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    req_valid = 2'b00;
   logic [1:0]    req_ready;
   logic [1:0]    req_we = 2'b00;
   logic [2*AW-1:0] req_addr = '0;
   logic [2*DW-1:0] req_wdata = '0;
   logic [1:0]    rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] bram_rd_addr;
   logic [AW-1:0] bram_wr_addr;
   logic [DW-1:0] bram_wr_data;
   logic          bram_we;
   logic [DW-1:0] bram_rd_data;
   logic          init_done;

   int checks = 0;
   int errors = 0;

   // clock
   always #5 clk = ~clk;

   bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .bram_rd_addr(bram_rd_addr), .bram_wr_addr(bram_wr_addr),
      .bram_wr_data(bram_wr_data), .bram_we(bram_we),
      .bram_rd_data(bram_rd_data), .init_done(init_done)
   );

   // BRAM tile model: synchronous write, RD_LAT-cycle registered read.
   logic [DW-1:0] mem [256];
   logic [DW-1:0] rd_q1, rd_q2;
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | i;
      rd_q1 = '0;
      rd_q2 = '0;
   end
   always @(posedge clk) begin
      if (bram_we) mem[bram_wr_addr] <= bram_wr_data;
      rd_q1 <= mem[bram_rd_addr];
      rd_q2 <= rd_q1;
   end
   assign bram_rd_data = (RD_LAT == 1) ? rd_q1 : rd_q2;

   // Watch for any response strobe inside a window that must stay silent.
   logic watch = 1'b0;
   logic saw_rsp = 1'b0;
   always @(negedge clk) if (watch && rsp_valid != 2'b00) saw_rsp = 1'b1;

   // Preloaded content of an address never written by the bench.
   function automatic logic [DW-1:0] pre(input logic [AW-1:0] a);
`ifdef BRAM_ARB_CLEAR_EN
      pre = '0;
`else
      pre = {16'hA5A5, 8'h00, a};
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]    valid;
      logic [1:0]    we;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;
      logic [1:0]    exp_ready;
      logic [1:0]    exp_rsp;
      logic [DW-1:0] exp_rdata;
      logic          exp_we;
      logic [AW-1:0] exp_waddr;
      logic [DW-1:0] exp_wdata;
   } vec_t;

   function automatic vec_t mk(
      input logic [1:0] valid, input logic [1:0] we,
      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
      input logic [1:0] exp_ready, input logic [1:0] exp_rsp,
      input logic [DW-1:0] exp_rdata, input logic exp_we,
      input logic [AW-1:0] exp_waddr, input logic [DW-1:0] exp_wdata);
      vec_t v;
      v.valid = valid; v.we = we; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
      v.exp_ready = exp_ready; v.exp_rsp = exp_rsp; v.exp_rdata = exp_rdata;
      v.exp_we = exp_we; v.exp_waddr = exp_waddr; v.exp_wdata = exp_wdata;
      return v;
   endfunction

   vec_t vecs [17];

   // Reset sequence: checks reset values, releases, and measures init time.
   task automatic do_reset(input logic [1:0] hold_valid);
      int  n;
      logic ready_bad;
      @(posedge clk); #1;
      rst_n = 1'b0; req_valid = hold_valid; req_we = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", req_ready, 2'b00);
      check("rst_rsp_valid", rsp_valid, 2'b00);
      check("rst_bram_we", bram_we, 1'b0);
      check("rst_rd_addr", bram_rd_addr, 0);
      check("rst_wr_addr", bram_wr_addr, 0);
      check("rst_wr_data", bram_wr_data, 0);
      check("rst_init_done", init_done, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      n = 0;
      ready_bad = 1'b0;
      @(negedge clk);
      check("first_cycle_bram_we", bram_we, 1'b0);
      while (!init_done && n < 400) begin
         if (req_ready != 2'b00) ready_bad = 1'b1;
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      req_valid = 2'b00;
      check("init_cycles", n, INIT_CYC);
      check("ready_low_in_init", ready_bad, 1'b0);
   endtask

   initial begin
      int n;
      vecs[0]  = mk(2'b01, 2'b01, 8'h10, 8'h00, 32'hDEADBEEF, 32'h0, 2'b01, 2'b00, 32'h0, 1'b0, 8'h0, 32'h0);
      vecs[1]  = mk(2'b01, 2'b00, 8'h10, 8'h00, 32'h0, 32'h0, 2'b01, 2'b00, 32'h0, 1'b1, 8'h10, 32'hDEADBEEF);
      vecs[2]  = mk(2'b10, 2'b10, 8'h00, 8'hFF, 32'h0, 32'h12345678, 2'b10, 2'b00, 32'h0, 1'b0, 8'h0, 32'h0);
      vecs[3]  = mk(2'b01, 2'b00, 8'hFF, 8'h00, 32'h0, 32'h0, 2'b01, 2'b01, 32'hDEADBEEF, 1'b1, 8'hFF, 32'h12345678);
      vecs[4]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0, 8'h0, 32'h0);
      vecs[5]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b00, 2'b01, 32'h12345678, 1'b0, 8'h0, 32'h0);
      vecs[6]  = mk(2'b10, 2'b00, 8'h00, 8'h03, 32'h0, 32'h0, 2'b10, 2'b00, 32'h0, 1'b0, 8'h0, 32'h0);
      vecs[7]  = mk(2'b11, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0, 2'b01, 2'b00, 32'h0, 1'b0, 8'h0, 32'h0);
      vecs[8]  = mk(2'b11, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0, 2'b10, 2'b10, pre(8'h03), 1'b0, 8'h0, 32'h0);
      vecs[9]  = mk(2'b11, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0, 2'b01, 2'b01, pre(8'h01), 1'b0, 8'h0, 32'h0);
      vecs[10] = mk(2'b11, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0, 2'b10, 2'b10, pre(8'h02), 1'b0, 8'h0, 32'h0);
      vecs[11] = mk(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b00, 2'b01, pre(8'h01), 1'b0, 8'h0, 32'h0);
      vecs[12] = mk(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b00, 2'b10, pre(8'h02), 1'b0, 8'h0, 32'h0);
      vecs[13] = mk(2'b11, 2'b01, 8'h20, 8'h21, 32'hCAFEF00D, 32'h0, 2'b01, 2'b00, 32'h0, 1'b0, 8'h0, 32'h0);
      vecs[14] = mk(2'b11, 2'b01, 8'h20, 8'h21, 32'hCAFEF00D, 32'h0, 2'b10, 2'b00, 32'h0, 1'b1, 8'h20, 32'hCAFEF00D);
      vecs[15] = mk(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0, 8'h0, 32'h0);
      vecs[16] = mk(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b00, 2'b10, pre(8'h21), 1'b0, 8'h0, 32'h0);

      do_reset(2'b00);

      // table-driven vectors: one record per cycle
      for (int i = 0; i < 17; i++) begin
         @(posedge clk); #1;
         req_valid = vecs[i].valid;
         req_we    = vecs[i].we;
         req_addr  = {vecs[i].a1, vecs[i].a0};
         req_wdata = {vecs[i].d1, vecs[i].d0};
         @(negedge clk);
         check($sformatf("v%0d_ready", i), req_ready, vecs[i].exp_ready);
         check($sformatf("v%0d_rsp_valid", i), rsp_valid, vecs[i].exp_rsp);
         if (vecs[i].exp_rsp != 2'b00)
            check($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
         check($sformatf("v%0d_bram_we", i), bram_we, vecs[i].exp_we);
         if (vecs[i].exp_we) begin
            check($sformatf("v%0d_wr_addr", i), bram_wr_addr, vecs[i].exp_waddr);
            check($sformatf("v%0d_wr_data", i), bram_wr_data, vecs[i].exp_wdata);
         end
      end

      // read latency: handshake to rsp_valid must be 1+RD_LAT cycles
      @(posedge clk); #1;
      req_valid = 2'b01; req_we = 2'b00; req_addr = {8'h00, 8'h40};
      @(negedge clk);
      check("lat_ready", req_ready, 2'b01);
      @(posedge clk); #1;
      req_valid = 2'b00;
      n = 1;
      @(negedge clk);
      check("lat_rd_addr", bram_rd_addr, 8'h40);
      while (rsp_valid == 2'b00 && n < 10) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      check("lat_cycles", n, 1 + RD_LAT);
      check("lat_rsp_valid", rsp_valid, 2'b01);
      check("lat_rdata", rsp_rdata, pre(8'h40));

      // reset mid-flight: accepted read must never respond
      @(posedge clk); #1;
      req_valid = 2'b10; req_we = 2'b00; req_addr = {8'h05, 8'h00};
      @(negedge clk);
      check("mid_ready", req_ready, 2'b10);
      @(posedge clk); #1;
      req_valid = 2'b00; rst_n = 1'b0; watch = 1'b1;
      @(negedge clk);
      check("mid_rsp_in_rst", rsp_valid, 2'b00);
      do_reset(2'b11);
      repeat (4) @(negedge clk);
      watch = 1'b0;
      check("mid_no_rsp", saw_rsp, 1'b0);

`ifdef BRAM_ARB_CLEAR_EN
      // zero-fill: previously written / preloaded words now read 0
      for (int k = 0; k < 3; k++) begin
         logic [AW-1:0] a;
         a = (k == 0) ? 8'h00 : (k == 1) ? 8'h7F : 8'hFF;
         @(posedge clk); #1;
         req_valid = 2'b01; req_we = 2'b00; req_addr = {8'h00, a};
         @(posedge clk); #1;
         req_valid = 2'b00;
         repeat (RD_LAT) @(posedge clk);
         @(negedge clk);
         check($sformatf("clr_rsp_valid_%0h", a), rsp_valid, 2'b01);
         check($sformatf("clr_rdata_%0h", a), rsp_rdata, 32'h0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
